coherence_bus_ctrl: RTL

- Bus/coherence controller directly downstream of the two MESI dcaches and two icaches.
- Serialises all cache-to-memory traffic onto the single RAM port.
- Issues snoops and invalidations so the dcache snoop states (SNOOPY, REPLY, INV, SUPPLY) have a counterpart.
- Implements cache-to-cache transfer of MODIFIED blocks, with simultaneous write-back to RAM.

---
 rtl/coherence_bus_ctrl_if.sv | 42 ++++
 rtl/coherence_bus_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/coherence_bus_ctrl_if.sv
// rtl/coherence_bus_ctrl_if.sv - cache-side and RAM-side signal bundle of the coherence bus controller
// Purpose: groups the icache, dcache, snoop and RAM signals of coherence_bus_ctrl.
// Modports:
//   master - the controller: drives wait/load/snoop outputs and RAM strobes.
//   slave  - the caches and RAM: drive requests, snoop responses and RAM status.
interface coherence_bus_ctrl_if;
   logic [1:0]        iREN;
   logic [1:0][31:0]  iaddr;
   logic [1:0]        iwait;
   logic [1:0][31:0]  iload;
   logic [1:0]        dREN;
   logic [1:0]        dWEN;
   logic [1:0][31:0]  daddr;
   logic [1:0][31:0]  dstore;
   logic [1:0]        ccwrite;
   logic [1:0]        cctrans;
   logic [1:0]        cchit;
   logic [1:0]        dwait;
   logic [1:0][31:0]  dload;
   logic [1:0]        ccwait;
   logic [1:0]        ccinv;
   logic [1:0][31:0]  ccsnoopaddr;
   logic [1:0]        ccexclusive;
   logic              ramREN;
   logic              ramWEN;
   logic [31:0]       ramaddr;
   logic [31:0]       ramstore;
   logic [31:0]       ramload;
   logic [1:0]        ramstate;

   modport master (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, cctrans, cchit, ramload, ramstate,
      output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr, ccexclusive,
             ramREN, ramWEN, ramaddr, ramstore
   );

   modport slave (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, cctrans, cchit, ramload, ramstate,
      input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr, ccexclusive,
             ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// rtl/coherence_bus_ctrl.sv - MESI bus/coherence controller serialising two cores onto one RAM port
// Purpose: arbitrates dcache write-backs, dcache fills/upgrades (with snooping of the other
//          core and cache-to-cache transfer of MODIFIED blocks) and icache fetches onto RAM.
// Ports:
//   CLK - rising-edge clock
//   RST - asynchronous active-high reset
//   bus - coherence_bus_ctrl_if.master (cache request/response, snoop and RAM signals)
module coherence_bus_ctrl #(
   parameter int CPUS      = 2,
   parameter int BLK_WORDS = 2
) (
   input logic                 CLK,
   input logic                 RST,
   coherence_bus_ctrl_if.master bus
);
   localparam int          BW         = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BLK_WORDS - 1);
   localparam logic [31:0] BLK_MASK   = ~(32'(BLK_WORDS * 4) - 32'd1);
   localparam logic [1:0]  RAM_ACCESS = 2'd2;

   typedef logic [CPUS-1:0] core_vec_t;
   typedef enum logic [2:0] {IDLE, SNOOP, C2C, LOAD, WB, IFETCH, UPGRADE_DONE} state_e;

   state_e        state_q, state_d;
   logic          rr_q, rr_d;
   logic          cur_q, cur_d;     // requester i / write-back core k / fetching core
   logic          upg_q, upg_d;     // granted request is an S->M upgrade
   logic          hit_q, hit_d;     // snooped core held the block
   logic [BW-1:0] beat_q, beat_d;

   core_vec_t dreq;
   logic      access;
   logic      last;
   logic      oth;

   // A dcache asks for the bus with a fill beat or an upgrade (ccwrite+cctrans without dREN).
   assign dreq   = bus.dREN | (bus.ccwrite & bus.cctrans);
   assign access = (bus.ramstate == RAM_ACCESS);
   assign last   = (beat_q == LAST_BEAT);
   assign oth    = ~cur_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
         cur_q   <= 1'b0;
         upg_q   <= 1'b0;
         hit_q   <= 1'b0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         cur_q   <= cur_d;
         upg_q   <= upg_d;
         hit_q   <= hit_d;
         beat_q  <= beat_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      rr_d             = rr_q;
      cur_d            = cur_q;
      upg_d            = upg_q;
      hit_d            = hit_q;
      beat_d           = beat_q;
      bus.iwait        = '1;
      bus.iload        = '0;
      bus.dwait        = '1;
      bus.dload        = '0;
      bus.ccwait       = '0;
      bus.ccinv        = '0;
      bus.ccsnoopaddr  = '0;
      bus.ccexclusive  = '0;
      bus.ramREN       = 1'b0;
      bus.ramWEN       = 1'b0;
      bus.ramaddr      = '0;
      bus.ramstore     = '0;

      case (state_q)
         IDLE: begin
            if (bus.dWEN[rr_q]) begin
               cur_d   = rr_q;
               state_d = WB;
            end else if (bus.dWEN[~rr_q]) begin
               cur_d   = ~rr_q;
               state_d = WB;
            end else if (dreq[rr_q]) begin
               cur_d   = rr_q;
               upg_d   = ~bus.dREN[rr_q];
               state_d = SNOOP;
            end else if (dreq[~rr_q]) begin
               cur_d   = ~rr_q;
               upg_d   = ~bus.dREN[~rr_q];
               state_d = SNOOP;
            end else if (bus.iREN[rr_q]) begin
               cur_d   = rr_q;
               state_d = IFETCH;
            end else if (bus.iREN[~rr_q]) begin
               cur_d   = ~rr_q;
               state_d = IFETCH;
            end
         end

         SNOOP: begin
            bus.ccwait[oth]      = 1'b1;
            bus.ccsnoopaddr[oth] = bus.daddr[cur_q] & BLK_MASK;
            bus.ccinv[oth]       = bus.ccwrite[cur_q];
            if (bus.cctrans[oth]) begin
               hit_d = bus.cchit[oth];
               if (bus.ccwrite[oth])
                  state_d = C2C;
               else if (upg_q)
                  state_d = UPGRADE_DONE;
               else
                  state_d = LOAD;
            end
         end

         // The owner's write-back beats double as the requester's fill beats.
         C2C: begin
            bus.ramWEN        = 1'b1;
            bus.ramaddr       = bus.daddr[oth];
            bus.ramstore      = bus.dstore[oth];
            bus.dload[cur_q]  = bus.dstore[oth];
            if (access) begin
               bus.dwait[cur_q] = 1'b0;
               bus.dwait[oth]   = 1'b0;
               beat_d           = last ? '0 : beat_q + BW'(1);
               if (last) begin
                  state_d = IDLE;
                  rr_d    = oth;
               end
            end
         end

         LOAD: begin
            bus.ramREN        = 1'b1;
            bus.ramaddr       = bus.daddr[cur_q];
            bus.dload[cur_q]  = bus.ramload;
            if (last)
               bus.ccexclusive[cur_q] = (~hit_q & ~bus.ccwrite[cur_q]) | bus.ccwrite[cur_q];
            if (access) begin
               bus.dwait[cur_q] = 1'b0;
               beat_d           = last ? '0 : beat_q + BW'(1);
               if (last) begin
                  state_d = IDLE;
                  rr_d    = oth;
               end
            end
         end

         WB: begin
            bus.ramWEN   = 1'b1;
            bus.ramaddr  = bus.daddr[cur_q];
            bus.ramstore = bus.dstore[cur_q];
            if (access) begin
               bus.dwait[cur_q] = 1'b0;
               beat_d           = last ? '0 : beat_q + BW'(1);
               if (last) begin
                  state_d = IDLE;
                  rr_d    = oth;
               end
            end
         end

         IFETCH: begin
            bus.ramREN        = 1'b1;
            bus.ramaddr       = bus.iaddr[cur_q];
            bus.iload[cur_q]  = bus.ramload;
            if (access) begin
               bus.iwait[cur_q] = 1'b0;
               state_d          = IDLE;
            end
         end

         UPGRADE_DONE: begin
            bus.dwait[cur_q] = 1'b0;
            state_d          = IDLE;
            rr_d             = oth;
         end

         default: state_d = IDLE;
      endcase
   end
endmodule
